// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store unit and its lane logic.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int OFS_W  = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    // Bit offset of the addressed lane inside the word; words have no offset.
    function automatic logic [4:0] lane_shift(input logic [OFS_W-1:0] ofs, input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_shift = {ofs, 3'b000};
            SZ_HALF: lane_shift = {ofs[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane
// replacement into an existing word for sub-word stores.
module lane_merge_extract
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [OFS_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] merged
);

    logic [4:0]        sh;
    logic [15:0]       lane;
    logic signed [7:0]  lane_b_s;
    logic signed [15:0] lane_h_s;
    logic [DATA_W-1:0] mask;

    assign sh       = lane_shift(offset, size);
    assign lane     = 16'(word >> sh);
    assign lane_b_s = lane[7:0];
    assign lane_h_s = lane;

    always_comb begin
        ldata = word;
        mask  = '0;
        case (size)
            SZ_BYTE: begin
                ldata = uns ? {24'h0, lane[7:0]} : DATA_W'(lane_b_s);
                mask  = 32'h0000_00FF;
            end
            SZ_HALF: begin
                ldata = uns ? {16'h0, lane} : DATA_W'(lane_h_s);
                mask  = 32'h0000_FFFF;
            end
            default: ;
        endcase
        merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit: byte/half/word requests onto a word-wide RAM, with
// read-modify-write for sub-word stores and access error reporting.
module lsu_subword
    import mem_pkg::*;
#(
    parameter int RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state, state_nxt;
    logic        accept, is_err, is_sub_st;
    logic [31:0] ldata, merged;
    logic [31:0] addr_p1, merged_p1;

    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == SZ_ILL)                                   access_err = 1'b1;
        else if (size == SZ_HALF && addr[0])                  access_err = 1'b1;
        else if (size == SZ_WORD && addr[1:0] != 2'b00)       access_err = 1'b1;
        else if ({2'b00, addr[31:OFS_W]} >= 32'(RAM_WORDS))   access_err = 1'b1;
        else                                                  access_err = 1'b0;
    endfunction

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign is_err    = access_err(req_size, req_addr);
    assign is_sub_st = req_we && (req_size == SZ_BYTE || req_size == SZ_HALF);

    lane_merge_extract u_lane (
        .word   (ram_rdata),
        .offset (req_addr[OFS_W-1:0]),
        .size   (req_size),
        .uns    (req_unsigned),
        .wdata  (req_wdata),
        .ldata  (ldata),
        .merged (merged)
    );

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = {req_addr[31:OFS_W], 2'b00};
        ram_wdata = req_wdata;
        case (state)
            ST_IDLE: begin
                if (accept && !is_err && req_we) begin
                    if (is_sub_st) state_nxt = ST_RMW_WR;
                    else           ram_we    = 1'b1;
                end
            end
            ST_RMW_WR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_p1;
                ram_wdata = merged_p1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset kills any write, including one already half-way through RMW.
        if (rst) ram_we = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            addr_p1   <= '0;
            merged_p1 <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            // p1 stage: response register and RMW write buffer
            if (state == ST_RMW_WR) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end else if (accept) begin
                if (is_err) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (is_sub_st) begin
                    addr_p1   <= ram_addr;
                    merged_p1 <= merged;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= req_we ? 32'h0 : ldata;
                end
            end
        end
    end

endmodule
